// File: rtl/count_seq_ctrl_if.sv
// Command channel for count_seq_ctrl: valid/ready handshake carrying
// the opcode plus the terminal value and reload mode used by START.
interface count_seq_ctrl_if #(
  parameter int WIDTH = 3
);
  logic             valid;
  logic             ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] limit;
  logic             reload;

  modport master (
    output valid,
    output op,
    output limit,
    output reload,
    input  ready
  );

  modport slave (
    input  valid,
    input  op,
    input  limit,
    input  reload,
    output ready
  );
endinterface

// File: rtl/count_seq_ctrl.sv
// Command-sequenced up-counter: START/STOP/PAUSE/CLEAR, one-shot or reload.
// Optional tick prescaler enabled by defining COUNT_SEQ_PRESCALE_EN.
module count_seq_ctrl #(
  parameter int WIDTH    = 3,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  count_seq_ctrl_if.slave  cmd,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             paused,
  output logic             tc,
  output logic             done,
  output logic [3:0]       wraps,
  output logic             err
);

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_PAUSE = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t           state;
  logic             ready;
  logic [WIDTH-1:0] limit;
  logic             reload;

  logic accept;
  logic is_start;
  logic is_stop;
  logic is_pause;
  logic is_clear;
  logic active;
  logic start_ok;
  logic stop_ok;
  logic pause_ok;
  logic tick;
  logic at_limit;

  assign cmd.ready = ready;
  assign accept    = cmd.valid && ready;

  assign is_start = (cmd.op == OP_START);
  assign is_stop  = (cmd.op == OP_STOP);
  assign is_pause = (cmd.op == OP_PAUSE);
  assign is_clear = (cmd.op == OP_CLEAR);

  assign active   = (state == S_RUN) || (state == S_PAUSE);
  assign start_ok = !active;
  assign stop_ok  = active;
  assign pause_ok = active;
  assign at_limit = (count == limit);

`ifdef COUNT_SEQ_PRESCALE_EN
  localparam int PW = $clog2(PRESCALE);

  logic [PW-1:0] pre;
  logic          pre_last;
  logic          pre_clr;

  assign pre_last = (pre == PW'(PRESCALE - 1));
  assign pre_clr  = accept &&
                    ((is_start && start_ok) ||
                     (is_stop && stop_ok) ||
                     is_clear);
  assign tick     = (state == S_RUN) && pre_last && !accept;

  // Holds its phase across PAUSE so resume continues mid-period.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
    end else if (pre_clr) begin
      pre <= '0;
    end else if ((state == S_RUN) && !accept) begin
      pre <= pre_last ? '0 : pre + PW'(1);
    end
  end
`else
  localparam int unused_prescale = PRESCALE;

  // A command on the same edge always wins over the tick.
  assign tick = (state == S_RUN) && !accept;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      ready  <= 1'b1;
      count  <= '0;
      wraps  <= 4'd0;
      limit  <= '0;
      reload <= 1'b0;
      busy   <= 1'b0;
      paused <= 1'b0;
      tc     <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      tc    <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      ready <= !accept;

      if (accept) begin
        unique case (1'b1)
          is_start: begin
            if (start_ok) begin
              state  <= S_RUN;
              busy   <= 1'b1;
              paused <= 1'b0;
              limit  <= cmd.limit;
              reload <= cmd.reload;
              count  <= '0;
              wraps  <= 4'd0;
            end else begin
              err <= 1'b1;
            end
          end
          is_stop: begin
            if (stop_ok) begin
              state  <= S_IDLE;
              busy   <= 1'b0;
              paused <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
          is_pause: begin
            if (pause_ok) begin
              if (state == S_RUN) begin
                state  <= S_PAUSE;
                paused <= 1'b1;
              end else begin
                state  <= S_RUN;
                paused <= 1'b0;
              end
            end else begin
              err <= 1'b1;
            end
          end
          is_clear: begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            paused <= 1'b0;
            count  <= '0;
            wraps  <= 4'd0;
          end
          default: begin
            err <= 1'b0;
          end
        endcase
      end else if (tick) begin
        if (at_limit) begin
          tc <= 1'b1;
          if (reload) begin
            count <= '0;
            if (wraps != 4'hF) begin
              wraps <= wraps + 4'd1;
            end
          end else begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end else begin
          count <= count + WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: doc/count_seq_ctrl.md
# count_seq_ctrl

Command-driven controller that sequences a small binary up-counter datapath: start, stop, pause/resume and clear, with programmable terminal value and one-shot or auto-reload operation. It sits between a command source (test sequencer or host FSM) and the counter, presenting count, terminal-count and done status. An optional prescaler slows the count rate.

## Interface
- WIDTH, 3, counter width; limit and count share this width.
- PRESCALE, 4, cycles per count tick when the prescaler is compiled in (≥2); ignored otherwise.

- clk  in  1  clock, all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  00 START, 01 STOP, 10 PAUSE (toggle pause/resume), 11 CLEAR.
- cmd_limit  in  WIDTH  terminal value, latched on accepted START.
- cmd_reload  in  1  1 = auto-reload, 0 = one-shot; latched on accepted START.
- count  out  WIDTH  current count.
- busy  out  1  high in RUN or PAUSE.
- paused  out  1  high in PAUSE.
- tc  out  1  one-cycle pulse, terminal count reached.
- done  out  1  one-cycle pulse, one-shot completed.
- wraps  out  4  reload counter, saturates at 15.
- err  out  1  one-cycle pulse, illegal command accepted.

## Operation
- States: IDLE, RUN, PAUSE, DONE. Command accepted on edge where cmd_valid & cmd_ready.
- START: from IDLE/DONE → RUN; latch limit/reload; count←0, wraps←0. From RUN/PAUSE → illegal.
- STOP: RUN/PAUSE → IDLE, count holds. From IDLE/DONE → illegal.
- PAUSE: RUN → PAUSE, PAUSE → RUN; count holds in PAUSE. From IDLE/DONE → illegal.
- CLEAR: any state → IDLE, count←0, wraps←0. Never illegal.
- Illegal command: accepted, no state/count change, err pulses.
- RUN tick with count≠limit: count←count+1.
- RUN tick with count==limit: tc pulses; reload=1 → count←0, wraps←min(wraps+1,15), stay RUN; reload=0 → DONE, count holds at limit, done pulses.
- limit=0: reload mode gives tc every tick, count stays 0; one-shot goes to DONE on first tick.
- Arithmetic modulo 2^WIDTH; limit=2^WIDTH−1 gives full-range counting.

## Timing
- Reset: state IDLE, count=0, wraps=0, cmd_ready=1, busy=paused=tc=done=err=0; latched limit=0, reload=0.
- cmd_ready drops for exactly one cycle after each accepted command, then returns to 1; max one command per two cycles.
- Command effects and err visible the cycle after the accepting edge.
- Without prescaler, tick = every RUN cycle: START accepted at edge N, count=0 after N, count=1 after N+1.
- tc, done registered: high in the cycle following the terminal edge (same cycle count shows 0 or holds limit).
- Command and tick on same edge: command wins, tick discarded, no tc/done.
- rst mid-operation overrides everything, reset values next cycle; no tc/done generated.

## Configuration
- COUNT_SEQ_PRESCALE_EN defined: tick once every PRESCALE RUN cycles; prescaler cleared on START, STOP, CLEAR and reset; holds in PAUSE, resumes from held value. START at edge N → first increment at edge N+PRESCALE.
- Not defined: tick every RUN cycle, PRESCALE unused, no prescaler logic.

## Test plan
- Reset, then START limit=3 reload=1, no prescaler → count 0,1,2,3,0,1…; tc with each 0 after 3; wraps 1,2,…, saturates at 15.
- START limit=5 reload=0 → count reaches 5, done and tc pulse once, state DONE, busy=0, count stays 5.
- RUN at count=2, PAUSE, wait 10 cycles, PAUSE → count 2 throughout pause, paused=1, then 3 next tick.
- STOP in IDLE and START in RUN → err pulses each, state/count unchanged; CLEAR in RUN → count=0, wraps=0, IDLE.
- Command on terminal edge (STOP at count==limit) → no tc, no done, IDLE, count holds limit; rst asserted in RUN → all outputs at reset values next cycle.
- With COUNT_SEQ_PRESCALE_EN, PRESCALE=4, limit=1 reload=1 → count changes every 4 cycles, tc every 8 cycles.
